// File: rtl/sched_deq_mux.sv
// Scheduler-driven dequeue mux: locks onto one input FIFO for a whole packet
// and forwards it through a registered 2-entry skid buffer.
module sched_deq_mux #(
    parameter int NUM_FIFO   = 12,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int SEL_WIDTH  = $clog2(NUM_FIFO)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SEL_WIDTH-1:0]           sel_in,
    input  logic                           en_in,
    input  logic [NUM_FIFO*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_FIFO*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_FIFO-1:0]            s_axis_tvalid,
    input  logic [NUM_FIFO-1:0]            s_axis_tlast,
    output logic [NUM_FIFO-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [NUM_FIFO-1:0]            pe_tlast,
    output logic                           busy,
    output logic                           sel_err,
    output logic [1:0]                     o_dbg_state
);

    // Handshake: a beat moves on a port only in a cycle where valid and ready
    // are both high; valid never depends on ready, and a valid beat holds its
    // payload until taken.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [SEL_WIDTH:0] NUM_FIFO_EXT = (SEL_WIDTH + 1)'(NUM_FIFO);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SEL_WIDTH-1:0]    r_cur_sel;
    logic [SEL_WIDTH-1:0]    w_cur_sel_nxt;

    logic                    w_sel_in_range;
    logic                    w_req_valid;
    logic                    w_cur_valid;
    logic                    w_cur_last;
    logic [DATA_WIDTH-1:0]   w_cur_data;
    logic [KEEP_WIDTH-1:0]   w_cur_keep;

    logic                    w_space;
    logic                    w_accept;
    logic                    w_pop;
    logic [NUM_FIFO-1:0]     w_tready;
    logic [NUM_FIFO-1:0]     w_cur_onehot;

    // Head entry doubles as the registered m_axis output; skid entry sits behind it.
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [KEEP_WIDTH-1:0]   r_out_keep;
    logic                    r_out_last;
    logic                    r_skd_valid;
    logic [DATA_WIDTH-1:0]   r_skd_data;
    logic [KEEP_WIDTH-1:0]   r_skd_keep;
    logic                    r_skd_last;

    logic [NUM_FIFO-1:0]     r_pe_tlast;
    logic                    r_sel_err;

    assign w_sel_in_range = ({1'b0, sel_in} < NUM_FIFO_EXT);

    always_comb begin
        w_req_valid  = 1'b0;
        w_cur_valid  = 1'b0;
        w_cur_last   = 1'b0;
        w_cur_data   = '0;
        w_cur_keep   = '0;
        w_cur_onehot = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            if (sel_in == SEL_WIDTH'(i)) begin
                w_req_valid = s_axis_tvalid[i];
            end
            if (r_cur_sel == SEL_WIDTH'(i)) begin
                w_cur_valid     = s_axis_tvalid[i];
                w_cur_last      = s_axis_tlast[i];
                w_cur_data      = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_cur_keep      = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_cur_onehot[i] = 1'b1;
            end
        end
    end

    assign w_space  = ~(r_out_valid & r_skd_valid);
    assign w_accept = (r_state == ST_XFER) & w_space & w_cur_valid;
    assign w_pop    = r_out_valid & m_axis_tready;

    always_comb begin
        w_tready = '0;
        if (r_state == ST_XFER && w_space) begin
            w_tready = w_cur_onehot;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_sel_nxt = r_cur_sel;
        case (r_state)
            ST_IDLE: begin
                if (en_in && w_sel_in_range && w_req_valid) begin
                    w_state_nxt   = ST_XFER;
                    w_cur_sel_nxt = sel_in;
                end
            end
            ST_XFER: begin
                if (w_accept && w_cur_last) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cur_sel <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_sel <= w_cur_sel_nxt;
        end
    end

    // Refill the head from the skid entry first so beat order is preserved.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_skd_valid <= 1'b0;
            r_skd_data  <= '0;
            r_skd_keep  <= '0;
            r_skd_last  <= 1'b0;
        end else if (w_pop || !r_out_valid) begin
            if (r_skd_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_skd_data;
                r_out_keep  <= r_skd_keep;
                r_out_last  <= r_skd_last;
                r_skd_valid <= w_accept;
                if (w_accept) begin
                    r_skd_data <= w_cur_data;
                    r_skd_keep <= w_cur_keep;
                    r_skd_last <= w_cur_last;
                end
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= w_cur_data;
                    r_out_keep <= w_cur_keep;
                    r_out_last <= w_cur_last;
                end
            end
        end else if (w_accept) begin
            r_skd_valid <= 1'b1;
            r_skd_data  <= w_cur_data;
            r_skd_keep  <= w_cur_keep;
            r_skd_last  <= w_cur_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pe_tlast <= '0;
            r_sel_err  <= 1'b0;
        end else begin
            r_pe_tlast <= (w_accept && w_cur_last) ? w_cur_onehot : '0;
            if (r_state == ST_IDLE && en_in && !w_sel_in_range) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;
    assign pe_tlast      = r_pe_tlast;
    assign busy          = (r_state != ST_IDLE);
    assign sel_err       = r_sel_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sched_deq_mux.sv
// Randomized bench for sched_deq_mux: per-FIFO packet sources, a queue-based
// reference of the egress stream and per-cycle checks of every output.
module tb_sched_deq_mux;

    localparam int NF = 12;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int SW = 4;
    localparam int BW = DW + KW + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [SW-1:0]    sel_in;
    logic             en_in;
    logic [NF*DW-1:0] s_axis_tdata;
    logic [NF*KW-1:0] s_axis_tkeep;
    logic [NF-1:0]    s_axis_tvalid;
    logic [NF-1:0]    s_axis_tlast;
    logic [NF-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic [NF-1:0]    pe_tlast;
    logic             busy;
    logic             sel_err;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    sched_deq_mux #(
        .NUM_FIFO   (NF),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sel_in        (sel_in),
        .en_in         (en_in),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pe_tlast      (pe_tlast),
        .busy          (busy),
        .sel_err       (sel_err),
        .o_dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus knobs
    int            p_en, p_valid, p_ready, sel_mode, force_len;
    bit            rst_force, p_rst_rand;
    logic [SW-1:0] sel_fix;
    logic [NF-1:0] valid_mask;

    // Packet sources, one per FIFO
    int             src_len [NF];
    int             src_idx [NF];
    int             src_seq [NF];
    logic [31:0]    src_rnd [NF];
    logic [KW-1:0]  src_keep[NF];
    bit             src_v   [NF];

    // Reference: egress stream as a queue of {last, keep, data}
    logic [BW-1:0]  exp_q[$];
    bit             m_xfer, m_gap, m_err, prev_rst_low;
    int             m_cur;
    logic [NF-1:0]  m_pe;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat_of(input int i);
        logic [DW-1:0] d;
        logic          l;
        d = {8'(i), 16'(src_seq[i]), 8'(src_idx[i]), src_rnd[i]};
        l = (src_idx[i] == src_len[i] - 1);
        return {l, src_keep[i], d};
    endfunction

    task automatic new_beat(input int i);
        src_rnd[i]  = $urandom;
        src_keep[i] = KW'($urandom);
    endtask

    task automatic new_pkt(input int i);
        src_seq[i]++;
        src_idx[i] = 0;
        src_len[i] = (force_len != 0) ? force_len : $urandom_range(1, 5);
        new_beat(i);
    endtask

    task automatic restart_all();
        for (int i = 0; i < NF; i++) new_pkt(i);
    endtask

    task automatic step();
        logic [BW-1:0] b;
        logic [NF-1:0] exp_ready;
        bit            acc, pop, lst;
        int            s;

        rst = (rst_force || (p_rst_rand && $urandom_range(0, 999) == 0)) ? 1'b0 : 1'b1;
        en_in = ($urandom_range(0, 99) < p_en);
        case (sel_mode)
            0:       sel_in = SW'($urandom_range(0, NF - 1));
            1:       sel_in = sel_fix;
            default: sel_in = SW'($urandom_range(0, 15));
        endcase
        m_axis_tready = ($urandom_range(0, 99) < p_ready);
        for (int i = 0; i < NF; i++) begin
            src_v[i] = valid_mask[i] && ($urandom_range(0, 99) < p_valid);
            b = beat_of(i);
            s_axis_tdata[i*DW +: DW] = b[DW-1:0];
            s_axis_tkeep[i*KW +: KW] = b[DW +: KW];
            s_axis_tlast[i]          = b[BW-1];
            s_axis_tvalid[i]         = src_v[i];
        end
        #1;

        exp_ready = (m_xfer && exp_q.size() < 2) ? (NF'(1) << m_cur) : '0;
        check("s_tready", 64'(s_axis_tready), 64'(exp_ready));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("m_tdata", 64'(m_axis_tdata), 64'(exp_q[0][DW-1:0]));
            check("m_tkeep", 64'(m_axis_tkeep), 64'(exp_q[0][DW +: KW]));
            check("m_tlast", 64'(m_axis_tlast), 64'(exp_q[0][BW-1]));
        end
        check("pe_tlast", 64'(pe_tlast), 64'(m_pe));
        check("busy", 64'(busy), 64'(m_xfer || m_gap));
        check("sel_err", 64'(sel_err), 64'(m_err));
        if (prev_rst_low) begin
            check("rst_tdata", 64'(m_axis_tdata), 64'(0));
            check("rst_tkeep", 64'(m_axis_tkeep), 64'(0));
            check("rst_tlast", 64'(m_axis_tlast), 64'(0));
        end

        if (!rst) begin
            exp_q.delete();
            m_xfer = 0; m_gap = 0; m_err = 0; m_cur = 0; m_pe = '0;
            prev_rst_low = 1;
            restart_all();
        end else begin
            prev_rst_low = 0;
            acc = m_xfer && (exp_q.size() < 2) && src_v[m_cur];
            pop = (exp_q.size() > 0) && m_axis_tready;
            if (pop) void'(exp_q.pop_front());
            m_pe = '0;
            lst  = 0;
            if (acc) begin
                b   = beat_of(m_cur);
                lst = b[BW-1];
                exp_q.push_back(b);
                if (lst) m_pe = NF'(1) << m_cur;
                src_idx[m_cur]++;
                if (src_idx[m_cur] == src_len[m_cur]) new_pkt(m_cur);
                else new_beat(m_cur);
            end
            if (m_gap) begin
                m_gap = 0;
            end else if (m_xfer) begin
                if (acc && lst) begin
                    m_xfer = 0;
                    m_gap  = 1;
                end
            end else if (en_in) begin
                if (int'(sel_in) >= NF) m_err = 1;
                else if (src_v[sel_in]) begin
                    m_xfer = 1;
                    m_cur  = int'(sel_in);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_knobs(input logic [NF-1:0] mask, input logic [SW-1:0] sel,
                             input int len, input int ready);
        valid_mask = mask;
        sel_fix    = sel;
        sel_mode   = 1;
        force_len  = len;
        p_ready    = ready;
        p_en       = 100;
        p_valid    = 100;
    endtask

    task automatic drain();
        p_en = 0; p_valid = 100; p_ready = 100; valid_mask = '1;
        run(12);
    endtask

    initial begin
        p_en = 0; p_valid = 0; p_ready = 100; sel_mode = 1; force_len = 4;
        rst_force = 1; p_rst_rand = 0; sel_fix = '0; valid_mask = '0;
        rst = 1'b0; en_in = 1'b0; sel_in = '0; m_axis_tready = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
        for (int i = 0; i < NF; i++) begin
            src_seq[i] = 0;
            src_v[i]   = 0;
        end
        restart_all();
        m_xfer = 0; m_gap = 0; m_err = 0; m_cur = 0; m_pe = '0; prev_rst_low = 1;
        repeat (2) @(posedge clk);
        #1;
        run(3);
        rst_force = 0;

        // 4-beat packet on FIFO5; scheduler moves to FIFO2 while it is locked
        set_knobs(NF'(1) << 5, 4'd5, 4, 100);
        restart_all();
        run(1);
        valid_mask = (NF'(1) << 5) | (NF'(1) << 2);
        sel_fix    = 4'd2;
        run(12);
        drain();

        // Egress back-pressure for 3 cycles mid-packet
        set_knobs(NF'(1) << 5, 4'd5, 4, 100);
        restart_all();
        run(3);
        p_ready = 0;
        run(3);
        p_ready = 100;
        run(8);
        drain();

        // Out-of-range selection, then sticky
        set_knobs('1, 4'd13, 3, 100);
        restart_all();
        run(4);
        sel_fix = 4'd3;
        run(8);
        drain();

        // Back-to-back single-beat packets on FIFO0
        set_knobs(NF'(1), 4'd0, 1, 100);
        restart_all();
        run(12);
        drain();

        // Reset on beat 2 of a 4-beat packet
        set_knobs(NF'(1) << 7, 4'd7, 4, 100);
        restart_all();
        run(2);
        rst_force = 1;
        run(1);
        rst_force = 0;
        p_en = 0;
        run(4);

        // Randomized traffic
        force_len  = 0;
        p_rst_rand = 1;
        for (int blk = 0; blk < 30; blk++) begin
            p_en       = $urandom_range(0, 100);
            p_valid    = $urandom_range(30, 100);
            p_ready    = $urandom_range(20, 100);
            sel_mode   = ($urandom_range(0, 3) == 0) ? 2 : 0;
            valid_mask = NF'($urandom);
            run(100);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sched_deq_mux.md
SCHED_DEQ_MUX -- requirements
Module: sched_deq_mux

Interface
REQ-001 The block SHALL have parameter NUM_FIFO, default 12, number of queued input FIFOs.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, stream data width in bits.
REQ-003 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 The block SHALL have parameter SEL_WIDTH, default $clog2(NUM_FIFO), selector width.
REQ-005 clk  input  1  the single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 sel_in  input  SEL_WIDTH  FIFO index chosen by the scheduler.
REQ-008 en_in  input  1  sel_in is valid this cycle.
REQ-009 s_axis_tdata  input  NUM_FIFO*DATA_WIDTH  per-FIFO data; FIFO i occupies slice i.
REQ-010 s_axis_tkeep  input  NUM_FIFO*KEEP_WIDTH  per-FIFO byte enables.
REQ-011 s_axis_tvalid, s_axis_tlast  input  NUM_FIFO each  per-FIFO valid and last.
REQ-012 s_axis_tready  output  NUM_FIFO  per-FIFO ready.
REQ-013 m_axis_tdata, m_axis_tkeep  output  DATA_WIDTH, KEEP_WIDTH  egress data and keep.
REQ-014 m_axis_tvalid, m_axis_tlast  output  1 each  egress valid and last.
REQ-015 m_axis_tready  input  1  egress ready.
REQ-016 pe_tlast  output  NUM_FIFO  one-cycle pulse per FIFO on packet completion, fed back to the scheduler.
REQ-017 busy  output  1  high while a packet is locked.
REQ-018 sel_err  output  1  sticky flag for an out-of-range selection.

Function
REQ-019 States SHALL be IDLE, XFER and GAP.
REQ-020 IDLE: if en_in=1, sel_in<NUM_FIFO and s_axis_tvalid[sel_in]=1, latch cur_sel<=sel_in and go to XFER; otherwise stay in IDLE.
REQ-021 IDLE with en_in=1 and sel_in>=NUM_FIFO: set sel_err=1, stay in IDLE, accept no beat.
REQ-022 IDLE with en_in=1 and s_axis_tvalid[sel_in]=0: no action, stay in IDLE.
REQ-023 XFER: s_axis_tready[cur_sel] = skid buffer has a free entry; all other s_axis_tready bits SHALL be 0 in every state.
REQ-024 XFER: sel_in and en_in SHALL be ignored; selection is locked for the whole packet.
REQ-025 A beat SHALL be accepted when s_axis_tvalid[cur_sel] and s_axis_tready[cur_sel] are both high.
REQ-026 Accepting a beat with s_axis_tlast[cur_sel]=1 SHALL move the FSM to GAP.
REQ-027 The cycle after that tlast beat, pe_tlast[cur_sel] SHALL be 1 for exactly one cycle; all other bits SHALL be 0.
REQ-028 GAP SHALL last exactly one cycle and then return to IDLE, giving the scheduler one cycle to update.
REQ-029 busy SHALL be 1 in XFER and GAP, and 0 in IDLE.
REQ-030 Egress SHALL pass through a 2-entry skid buffer: an accepted beat appears on m_axis no earlier than 1 cycle later.
REQ-031 m_axis_* outputs SHALL be registered, and beat order SHALL be preserved.
REQ-032 With m_axis_tready held at 1, throughput SHALL be 1 beat per cycle inside a packet.
REQ-033 Packet overhead SHALL be 2 idle input cycles (GAP, then IDLE re-grant) between back-to-back packets.
REQ-034 m_axis_tvalid SHALL NOT drop once asserted until the beat is taken.
REQ-035 m_axis_tdata, m_axis_tkeep and m_axis_tlast SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-036 When the skid buffer is full, s_axis_tready[cur_sel] SHALL be 0; no beat is lost and none is duplicated.
REQ-037 A single-beat packet (tlast on the first beat) SHALL be legal: XFER for 1 cycle, then GAP.
REQ-038 Mid-packet loss of s_axis_tvalid[cur_sel] SHALL stall in XFER with no timeout.

Reset
REQ-039 While rst=0 at a clock edge, the block SHALL reset: FSM=IDLE, cur_sel=0, skid buffer empty.
REQ-040 Reset values SHALL be: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0, pe_tlast=0, busy=0, sel_err=0.
REQ-041 Reset mid-packet SHALL discard buffered beats and generate no pe_tlast pulse; the upstream remainder is the upstream's responsibility.
REQ-042 sel_err SHALL clear only on reset.

Verification
REQ-043 Scenario: NUM_FIFO=12; en_in=1, sel_in=5, FIFO5 sends a 4-beat packet, m_axis_tready=1 -> 4 beats out in order starting 1 cycle after the first accept; pe_tlast=12'h020 for 1 cycle after the last accept; busy high for 5 cycles.
REQ-044 Scenario: during the FIFO5 packet, sel_in switches to 2 with FIFO2 valid -> s_axis_tready[2] stays 0 until FIFO5 completes.
REQ-045 Scenario: m_axis_tready=0 for 3 cycles mid-packet -> at most 2 beats buffered, s_axis_tready[5]=0, output held stable, no beat lost after release.
REQ-046 Scenario: en_in=1, sel_in=13 -> sel_err=1 and stays 1; FSM stays IDLE; all s_axis_tready=0.
REQ-047 Scenario: single-beat packets back-to-back on FIFO0 with en_in held -> new grant every 3 cycles, pe_tlast[0] pulses each time.
REQ-048 Scenario: rst=0 asserted on beat 2 of 4 -> next cycle all outputs are at reset values and no pe_tlast pulse occurs.
